// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared controller/detector state types and the 1-0-1 detector next-state function
package seq_detect_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} ctrl_state_t;
  typedef enum logic [1:0] {A, B, C, D} det_state_t;
  function automatic det_state_t det_next(det_state_t s, logic b);
    return (s == C && b) ? D : b ? B : (s == B || s == D) ? C : A;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or above ptr, with wrap
//   req: request vector; ptr: search start index; win: one-hot winner; idx: winner index; any: some req set
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = $clog2(N)'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    win = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one shared overlapping 1-0-1 detector time-shared round-robin among NREQ serial requesters
//   req/bit_data/bit_valid: per-requester request, serial bit and bit qualifier
//   grant: one-hot owner of the detector; done/done_id/aborted/match_count: registered per-frame result
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         bit_data,
  input  logic [NREQ-1:0]         bit_valid,
  output logic [NREQ-1:0]         grant,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    aborted,
  output logic [CNT_W-1:0]        match_count
);
  localparam int IW = $clog2(NREQ);
  ctrl_state_t state;
  det_state_t det, det_nx;
  logic [IW-1:0] rr_ptr, g, arb_idx;
  logic [NREQ-1:0] arb_win;
  logic arb_any, acc, ab, last;
  logic [7:0] bit_cnt;
  logic [CNT_W-1:0] cnt, cnt_nx;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .win(arb_win),
    .idx(arb_idx),
    .any(arb_any)
  );
  always_comb begin
    ab = !req[g];
    acc = bit_valid[g];
    det_nx = det_next(det, bit_data[g]);
    cnt_nx = (det_nx == D && cnt != '1) ? cnt + 1'b1 : cnt;
    last = bit_cnt == 8'(FRAME_LEN - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      done <= 1'b0;
      done_id <= '0;
      aborted <= 1'b0;
      match_count <= '0;
      rr_ptr <= '0;
      g <= '0;
      det <= A;
      bit_cnt <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (arb_any) begin
          state <= BUSY;
          grant <= arb_win;
          g <= arb_idx;
          det <= A;
          bit_cnt <= '0;
          cnt <= '0;
        end
        // a dropped request wins over a same-cycle final bit, which is discarded
        BUSY: if (ab) begin
          state <= DONE;
          grant <= '0;
          done <= 1'b1;
          done_id <= g;
          aborted <= 1'b1;
          match_count <= '0;
        end else if (acc) begin
          det <= det_nx;
          bit_cnt <= bit_cnt + 1'b1;
          cnt <= cnt_nx;
          if (last) begin
            state <= DONE;
            grant <= '0;
            done <= 1'b1;
            done_id <= g;
            aborted <= 1'b0;
            match_count <= cnt_nx;
          end
        end
        DONE: begin
          state <= IDLE;
          rr_ptr <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: scoreboard bench for seq_detect_sched (default build plus a small saturating build)
module tb_seq_detect_sched;
  typedef struct {
    int id;
    int ab;
    int cnt;
  } res_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, reset1;
  logic [3:0] req, bit_data, bit_valid, grant;
  logic [3:0] req1, bit_data1, bit_valid1, grant1;
  logic done, aborted, done1, aborted1;
  logic [1:0] done_id, done_id1;
  logic [3:0] match_count;
  logic [1:0] match_count1;
  int n_tests = 0, n_fail = 0;
  res_t sb[$], sb1[$];
  res_t e, e1;
  int bits[$];
  int idx, cyc;
  seq_detect_sched #(.NREQ(4), .FRAME_LEN(8), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .bit_data(bit_data), .bit_valid(bit_valid),
    .grant(grant), .done(done), .done_id(done_id), .aborted(aborted), .match_count(match_count)
  );
  seq_detect_sched #(.NREQ(4), .FRAME_LEN(16), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset1), .req(req1), .bit_data(bit_data1), .bit_valid(bit_valid1),
    .grant(grant1), .done(done1), .done_id(done_id1), .aborted(aborted1), .match_count(match_count1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int exp_cnt(input int b[$], input int maxv);
    int a[$];
    int n = 0;
    foreach (b[i]) if (b[i] != 2) a.push_back(b[i]);
    for (int i = 2; i < a.size(); i++) if (a[i-2] == 1 && a[i-1] == 0 && a[i] == 1) n++;
    return n > maxv ? maxv : n;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_id", 32'(done_id), e.id);
        chk("aborted", 32'(aborted), e.ab);
        chk("match_count", 32'(match_count), e.cnt);
      end
    end
    if (done1) begin
      if (sb1.size() == 0) chk("unexpected_done_sat", 1, 0);
      else begin
        e1 = sb1.pop_front();
        chk("sat_done_id", 32'(done_id1), e1.id);
        chk("sat_aborted", 32'(aborted1), e1.ab);
        chk("sat_match_count", 32'(match_count1), e1.cnt);
      end
    end
  end
  task automatic wait_grant(output int wi, output int wc);
    wi = -1;
    wc = 0;
    for (int k = 0; k < 20 && grant == 0; k++) begin
      @(negedge clk);
      wc++;
    end
    if (grant == 0) chk("grant_timeout", 0, 1);
    else for (int k = 0; k < 4; k++) if (grant[k]) wi = k;
  endtask
  task automatic send_bits(input int id, input bit noise);
    foreach (bits[k]) begin
      bit_valid[id] = bits[k] != 2;
      bit_data[id] = bits[k] == 1;
      if (noise) begin
        bit_valid[1] = ~bit_valid[1];
        bit_data[1] = 1'b1;
      end
      @(negedge clk);
    end
    bit_valid = '0;
    bit_data = '0;
  endtask
  task automatic push(input int id, input int ab, input int cnt);
    sb.push_back(res_t'{id, ab, cnt});
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    reset1 = 1'b1;
    req = '0;
    bit_data = '0;
    bit_valid = '0;
    req1 = '0;
    bit_data1 = '0;
    bit_valid1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_match_count", 32'(match_count), 0);
    reset = 1'b0;
    reset1 = 1'b0;
    // single frame, three overlapping matches
    req = 4'b0001;
    wait_grant(idx, cyc);
    chk("t1_grant", 32'(grant), 1);
    chk("t1_latency", cyc, 1);
    bits = '{1, 0, 1, 0, 1, 1, 0, 1};
    push(0, 0, exp_cnt(bits, 15));
    send_bits(0, 0);
    req = '0;
    repeat (2) @(negedge clk);
    // fresh pointer, then full round robin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(idx, cyc);
      chk("rr_id", idx, i % 4);
      chk("rr_gap", cyc, i == 0 ? 1 : 2);
      bits = '{0, 0, 0, 0, 0, 0, 0, 0};
      push(i % 4, 0, exp_cnt(bits, 15));
      send_bits(idx, 0);
      if (i == 4) req = '0;
    end
    repeat (2) @(negedge clk);
    // gaps on the granted lane, noise on lane 1
    req = 4'b0100;
    wait_grant(idx, cyc);
    chk("stall_id", idx, 2);
    bits = '{1, 2, 0, 2, 2, 1, 0, 0, 0, 0, 0};
    push(2, 0, exp_cnt(bits, 15));
    send_bits(2, 1);
    req = '0;
    repeat (2) @(negedge clk);
    // abort after three bits, pointer then moves past the aborted requester
    req = 4'b0010;
    wait_grant(idx, cyc);
    chk("abort_id", idx, 1);
    bits = '{1, 0, 1};
    push(1, 1, 0);
    send_bits(1, 0);
    req = '0;
    @(negedge clk);
    req = 4'b1111;
    wait_grant(idx, cyc);
    chk("abort_rr_next", idx, 2);
    push(2, 1, 0);
    req = '0;
    repeat (3) @(negedge clk);
    // abort coinciding with the final bit
    req = 4'b0001;
    wait_grant(idx, cyc);
    chk("prio_id", idx, 0);
    bits = '{1, 0, 1, 0, 1, 1, 0};
    send_bits(0, 0);
    push(0, 1, 0);
    bit_valid[0] = 1'b1;
    bit_data[0] = 1'b1;
    req = '0;
    @(negedge clk);
    bit_valid = '0;
    bit_data = '0;
    repeat (2) @(negedge clk);
    // reset in the middle of a frame
    req = 4'b1000;
    wait_grant(idx, cyc);
    chk("mid_id", idx, 3);
    bits = '{1, 0, 1, 1};
    send_bits(3, 0);
    reset = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_done", 32'(done), 0);
    reset = 1'b0;
    wait_grant(idx, cyc);
    chk("post_rst_id", idx, 1);
    chk("post_rst_latency", cyc, 1);
    bits = '{1, 0, 1, 0, 1, 0, 1, 0};
    push(1, 0, exp_cnt(bits, 15));
    send_bits(1, 0);
    req = '0;
    repeat (2) @(negedge clk);
    // saturating build
    req1 = 4'b0001;
    for (int k = 0; k < 20 && grant1 == 0; k++) @(negedge clk);
    chk("sat_grant", 32'(grant1), 1);
    bits = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    sb1.push_back(res_t'{0, 0, exp_cnt(bits, 3)});
    foreach (bits[k]) begin
      bit_valid1[0] = 1'b1;
      bit_data1[0] = bits[k] == 1;
      @(negedge clk);
    end
    bit_valid1 = '0;
    req1 = '0;
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("sb_sat_empty", sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Shares one overlapping "1-0-1" serial sequence detector among NREQ bit-serial requesters.
- Arbitrates round-robin and grants one requester at a time.
- Runs the detector over exactly FRAME_LEN accepted bits, then reports the match count for that frame.
- Sits between the serial front-end channels and the status/statistics logic.

Parameters:
- NREQ, 4, number of requesters (2..16).
- FRAME_LEN, 8, bits per frame (2..255).
- CNT_W, 4, match counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  req[i] high while requester i wants or holds service.
- bit_data  in  NREQ  serial bit from requester i.
- bit_valid  in  NREQ  bit_data[i] is valid this cycle.
- grant  out  NREQ  one-hot grant; bits are accepted only from the granted requester.
- done  out  1  one-cycle pulse carrying a frame result.
- done_id  out  $clog2(NREQ)  requester index of the result.
- aborted  out  1  qualifies done; frame ended early.
- match_count  out  CNT_W  matches in the frame; 0 when aborted.

Behaviour:
- Reset is decided: reset is synchronous, active-high; clock is clk.
- Reset values: state=IDLE, grant=0, done=0, done_id=0, aborted=0, match_count=0, rr_ptr=0, det=A, bit_cnt=0, cnt=0.
- Controller FSM (all outputs registered):
  - IDLE: if req!=0, pick the first set req bit searching from rr_ptr upward with wrap. Next cycle: BUSY, grant one-hot on the winner, det=A, bit_cnt=0, cnt=0.
  - BUSY: a bit is accepted when bit_valid[g] is high, where g is the granted index.
    - Each accepted bit steps the detector and increments bit_cnt.
    - bit_valid on non-granted lanes is ignored.
    - Gaps (valid low) stall with no state change.
  - BUSY -> DONE on the accepted bit that makes bit_cnt==FRAME_LEN. grant drops in the DONE cycle.
  - BUSY -> DONE with aborted=1 if req[g] is low in any BUSY cycle. Abort takes priority over a same-cycle final bit; that bit is not counted.
  - DONE: done=1 for exactly one cycle, with done_id=g, match_count, and aborted valid alongside. Set rr_ptr=(g+1) mod NREQ. Next state IDLE.
  - Minimum spacing between grants: one IDLE cycle after DONE.
- Detector (Moore, 4 states), applied per accepted bit:
  - A: 1->B, 0->A.
  - B: 1->B, 0->C.
  - C: 1->D, 0->A.
  - D: 1->B, 0->C.
  - Matches overlap: cnt increments when the next state is D, so 1,0,1,0,1 gives 2 matches.
  - cnt saturates at 2^CNT_W-1 and never wraps.
- Detector state and cnt reset to A/0 at every new grant; nothing carries over between frames.
- The first frame after reset is granted from index 0.
- A requester that deasserts req in IDLE is simply skipped.
- Reset mid-frame: grant clears next edge, no done pulse, rr_ptr returns to 0.
- Outputs not in DONE: done=0. done_id, aborted and match_count hold their last values.

Decomposition:
- Package seq_detect_pkg:
  - ctrl_state_t enum {IDLE, BUSY, DONE}.
  - det_state_t enum {A, B, C, D}.
  - Function det_next(det_state_t, bit).
- Sub-module rr_arbiter: inputs req and rr_ptr, outputs the combinational one-hot winner and its index. Reusable elsewhere.
- Detector stays inline: 4 states plus counter.

Test Plan:
- Single frame, NREQ=4, req=0001, bits 1,0,1,0,1,1,0,1 with valid every cycle:
  - grant=0001 one cycle after req.
  - done on the cycle after the 8th bit, with done_id=0, match_count=3, aborted=0.
- Round-robin: req=1111 held, each requester sends 8 zeros -> done_id sequence 0,1,2,3,0, every match_count=0, one IDLE cycle between grants.
- Stalls and ignored lanes: granted lane 2 sends 1,_,0,_,_,1 then five zeros (_ = valid low), while lane 1 toggles bit_valid -> match_count=1; lane 1 traffic has no effect.
- Abort: requester 1 drops req after 3 bits (1,0,1) -> done with aborted=1, match_count=0, done_id=1; rr_ptr advances to 2.
- Saturation: CNT_W=2, FRAME_LEN=16, alternating 1,0,... -> match_count=3 (raw 7, clamped).
- Reset mid-frame after 4 bits -> grant=0 next cycle, no done pulse; with req=0110 after reset, the first grant goes to index 1.
